// File: rtl/conv_tuser_gen_pkg.sv
// Shared definitions for the TUSER tagger: field widths, TUSER bit layout
// and the layout of the config beat.
package conv_tuser_gen_pkg;

   localparam int KW_MAX    = 7;
   localparam int KW2_MAX   = KW_MAX / 2;
   localparam int BITS_KW2  = $clog2(KW2_MAX + 1);
   localparam int BITS_COLS = 10;
   localparam int BITS_CIN  = 10;
   localparam int BITS_ROWS = 10;

   localparam int I_IS_CONFIG    = 0;
   localparam int I_KW2          = 1;
   localparam int I_IS_CIN_LAST  = I_KW2 + BITS_KW2;
   localparam int I_IS_COLS_1_K2 = I_IS_CIN_LAST + 1;
   localparam int TUSER_WIDTH    = I_IS_COLS_1_K2 + 1;

   // Config beat fields, packed from bit 0 with kw2 in the least significant bits.
   typedef struct packed {
      logic [BITS_ROWS-1:0] rows_1;
      logic [BITS_CIN-1:0]  cin_1;
      logic [BITS_COLS-1:0] cols_1;
      logic [BITS_KW2-1:0]  kw2;
   } cfg_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Full-throughput two-entry register slice. The ready output is registered and
// only drops once the output register is stalled and a second beat has been
// parked in the skid register.
module axis_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);

   logic             ready_q;
   logic             valid_q;
   logic             skid_valid_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] skid_q;
   logic             in_acc;

   assign in_acc      = in_valid_i & ready_q;
   assign in_ready_o  = ready_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   // Output register refills straight from the input when free, otherwise the
   // incoming beat is parked in the skid register and ready is withdrawn.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ready_q      <= 1'b0;
         valid_q      <= 1'b0;
         skid_valid_q <= 1'b0;
         data_q       <= '0;
         skid_q       <= '0;
      end else if (!skid_valid_q) begin
         ready_q <= 1'b1;
         if (!valid_q || out_ready_i) begin
            valid_q <= in_acc;
            if (in_acc) data_q <= in_data_i;
         end else if (in_acc) begin
            skid_q       <= in_data_i;
            skid_valid_q <= 1'b1;
            ready_q      <= 1'b0;
         end
      end else if (out_ready_i) begin
         data_q       <= skid_q;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end
   end

endmodule

// File: rtl/conv_tuser_gen.sv
// Tags each beat of the raw pixel stream with TUSER flags derived from the
// leading config beat and the cin/col/row loop position, then registers the
// tagged beat through a skid stage towards the pad filter.
//
//   state  | meaning
//   ST_CFG | next accepted beat is a config beat
//   ST_RUN | data beats of a frame; counters track cin/col/row position
module conv_tuser_gen
   import conv_tuser_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_WIDTH-1:0]  s_data,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic [TUSER_WIDTH-1:0] m_user,
   output logic                   m_last,
   output logic                   cfg_err
);

   localparam int SKID_W = DATA_WIDTH + TUSER_WIDTH + 1;

   typedef enum logic {ST_CFG, ST_RUN} state_t;

   state_t               state_q;
   logic [BITS_KW2-1:0]  kw2_q;
   logic [BITS_COLS-1:0] cols_1_q;
   logic [BITS_CIN-1:0]  cin_1_q;
   logic [BITS_ROWS-1:0] rows_1_q;
   logic [BITS_CIN-1:0]  cin_cnt_q;
   logic [BITS_COLS-1:0] col_cnt_q;
   logic [BITS_ROWS-1:0] row_cnt_q;
   logic                 cfg_err_q;

   cfg_t                 cfg_in;
   logic                 accept;
   logic                 cfg_bad;
   logic                 cin_wrap;
   logic                 col_wrap;
   logic                 row_wrap;
   logic                 is_last_run;
   logic [BITS_COLS-1:0] k2_col;
   logic [TUSER_WIDTH-1:0] tag_user_d;
   logic                 tag_last_d;
   logic [SKID_W-1:0]    skid_out;

   assign cfg_in      = cfg_t'(s_data[$bits(cfg_t)-1:0]);
   assign accept      = s_valid & s_ready;
   // A kernel wider than the frame, or beyond the supported size, is flagged
   // and the frame runs with kw2 forced to 0 so no right-edge tag is produced.
   assign cfg_bad     = (cfg_in.cols_1 < BITS_COLS'(cfg_in.kw2)) ||
                        (32'(cfg_in.kw2) > 32'(KW2_MAX));
   assign cin_wrap    = (cin_cnt_q == cin_1_q);
   assign col_wrap    = (col_cnt_q == cols_1_q);
   assign row_wrap    = (row_cnt_q == rows_1_q);
   assign is_last_run = cin_wrap & col_wrap & row_wrap;
   // kw2_q never exceeds cols_1_q, so this cannot underflow.
   assign k2_col      = cols_1_q - BITS_COLS'(kw2_q);
   assign cfg_err     = cfg_err_q;

   // Tag for the beat currently presented on s_*.
   always_comb begin
      tag_user_d = '0;
      tag_last_d = 1'b0;
      if (state_q == ST_CFG) begin
         tag_user_d[I_IS_CONFIG]         = 1'b1;
         tag_user_d[I_KW2 +: BITS_KW2]   = cfg_bad ? '0 : cfg_in.kw2;
      end else begin
         tag_user_d[I_KW2 +: BITS_KW2]   = kw2_q;
         tag_user_d[I_IS_CIN_LAST]       = cin_wrap;
         tag_user_d[I_IS_COLS_1_K2]      = (kw2_q != '0) && (col_cnt_q == k2_col);
         tag_last_d                      = is_last_run;
      end
   end

   // Frame FSM: latch config, advance cin/col/row on every accepted data beat.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= ST_CFG;
         kw2_q     <= '0;
         cols_1_q  <= '0;
         cin_1_q   <= '0;
         rows_1_q  <= '0;
         cin_cnt_q <= '0;
         col_cnt_q <= '0;
         row_cnt_q <= '0;
         cfg_err_q <= 1'b0;
      end else if (accept) begin
         if (state_q == ST_CFG) begin
            kw2_q     <= cfg_bad ? '0 : cfg_in.kw2;
            cols_1_q  <= cfg_in.cols_1;
            cin_1_q   <= cfg_in.cin_1;
            rows_1_q  <= cfg_in.rows_1;
            cin_cnt_q <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            if (cfg_bad) cfg_err_q <= 1'b1;
            state_q   <= ST_RUN;
         end else begin
            if (s_last != is_last_run) cfg_err_q <= 1'b1;
            if (is_last_run) begin
               cin_cnt_q <= '0;
               col_cnt_q <= '0;
               row_cnt_q <= '0;
               state_q   <= ST_CFG;
            end else if (cin_wrap) begin
               cin_cnt_q <= '0;
               if (col_wrap) begin
                  col_cnt_q <= '0;
                  row_cnt_q <= row_cnt_q + 1'b1;
               end else begin
                  col_cnt_q <= col_cnt_q + 1'b1;
               end
            end else begin
               cin_cnt_q <= cin_cnt_q + 1'b1;
            end
         end
      end
   end

   axis_skid_buffer #(
      .WIDTH (SKID_W)
   ) u_skid (
      .clk_i       (aclk),
      .rst_i       (areset),
      .in_valid_i  (s_valid),
      .in_ready_o  (s_ready),
      .in_data_i   ({s_data, tag_user_d, tag_last_d}),
      .out_valid_o (m_valid),
      .out_ready_i (m_ready),
      .out_data_o  (skid_out)
   );

   assign m_data = skid_out[SKID_W-1 -: DATA_WIDTH];
   assign m_user = skid_out[TUSER_WIDTH:1];
   assign m_last = skid_out[0];

endmodule

// File: tb/tb_conv_tuser_gen.sv
// Directed bench for conv_tuser_gen: expected beats come from a nested-loop
// frame model, output beats are checked in order, and stall stability is
// checked on every held cycle.
module tb_conv_tuser_gen;
   import conv_tuser_gen_pkg::*;

   localparam int DW = 64;
   localparam int UW = TUSER_WIDTH;
   localparam int BW = DW + UW + 1;

   logic          aclk    = 1'b0;
   logic          areset  = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data  = '0;
   logic          s_last  = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic [UW-1:0] m_user;
   logic          m_last;
   logic          cfg_err;

   int vectors     = 0;
   int miscompares = 0;

   logic [BW-1:0] exp_q[$];
   int n_out = 0, n_k2 = 0, n_cinlast = 0, n_last = 0;
   bit rnd_ready = 1'b0;
   bit rnd_valid = 1'b0;
   logic          stall_q = 1'b0;
   logic [BW-1:0] held    = '0;
   logic [BW-1:0] exp_b;

   conv_tuser_gen #(.DATA_WIDTH(DW)) dut (
      .aclk    (aclk),
      .areset  (areset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_user  (m_user),
      .m_last  (m_last),
      .cfg_err (cfg_err)
   );

   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Output monitor at the falling edge: in-order scoreboard plus stall hold.
   always @(negedge aclk) begin
      if (areset) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            vectors++;
            assert ({m_valid, m_data, m_user, m_last} === {1'b1, held})
            else begin
               miscompares++;
               $error("FAIL stall_hold observed=%h expected=%h", {m_valid, m_data, m_user, m_last}, {1'b1, held});
            end
         end
         if (m_valid && m_ready) begin
            vectors++;
            assert (exp_q.size() != 0)
            else begin
               miscompares++;
               $error("FAIL extra_beat observed=%h expected=none", {m_data, m_user, m_last});
            end
            if (exp_q.size() != 0) begin
               exp_b = exp_q.pop_front();
               vectors++;
               assert ({m_data, m_user, m_last} === exp_b)
               else begin
                  miscompares++;
                  $error("FAIL beat observed=%h expected=%h", {m_data, m_user, m_last}, exp_b);
               end
            end
            n_out++;
            n_k2      += int'(m_user[I_IS_COLS_1_K2]);
            n_cinlast += int'(m_user[I_IS_CIN_LAST]);
            n_last    += int'(m_last);
         end
         stall_q = m_valid && !m_ready;
         held    = {m_data, m_user, m_last};
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      bit acc;
      int guard;
      if (rnd_valid) while ($urandom_range(0, 2) == 0) tick();
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      guard   = 0;
      forever begin
         acc = s_ready;
         tick();
         if (acc) break;
         guard++;
         if (guard > 200) begin
            $display("FAIL s_accept_timeout observed=no_accept expected=accept");
            $fatal(1, "input stuck");
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Frame model: config beat followed by rows x cols x cin data beats.
   // early >= 0 drives s_last on that data-beat index instead of the true last.
   task automatic send_frame(input logic [1:0] kw2, input logic [9:0] cols_1,
                             input logic [9:0] cin_1, input logic [9:0] rows_1,
                             input int early, input logic exp_err);
      logic [1:0]    kw2e;
      logic [DW-1:0] w;
      logic [UW-1:0] u;
      logic          lst;
      logic          sl;
      int            idx;
      kw2e = (int'(cols_1) < int'(kw2)) ? 2'd0 : kw2;
      w = {$urandom, $urandom};
      w[31:0] = {rows_1, cin_1, cols_1, kw2};
      u = '0;
      u[I_IS_CONFIG] = 1'b1;
      u[I_KW2 +: BITS_KW2] = kw2e;
      exp_q.push_back({w, u, 1'b0});
      send_beat(w, 1'b0);
      chk("cfg_err_after_cfg", 64'(cfg_err), 64'(exp_err));
      idx = 0;
      for (int r = 0; r <= int'(rows_1); r++)
         for (int c = 0; c <= int'(cols_1); c++)
            for (int ci = 0; ci <= int'(cin_1); ci++) begin
               lst = (r == int'(rows_1)) && (c == int'(cols_1)) && (ci == int'(cin_1));
               u = '0;
               u[I_KW2 +: BITS_KW2] = kw2e;
               u[I_IS_CIN_LAST]     = (ci == int'(cin_1));
               u[I_IS_COLS_1_K2]    = (kw2e != 2'd0) && (c == int'(cols_1) - int'(kw2e));
               w = {$urandom, $urandom};
               exp_q.push_back({w, u, lst});
               sl = (early >= 0) ? (idx == early) : lst;
               send_beat(w, sl);
               idx++;
            end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0) && (g < 300)) begin
         tick();
         g++;
      end
      tick();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      areset = 1'b1;
      exp_q.delete();
      tick();
      tick();
      areset = 1'b0;
   endtask

   int b_out, b_k2, b_cl, b_last;

   initial begin
      // Reset state
      tick();
      chk("rst_s_ready",  64'(s_ready), 64'd0);
      chk("rst_m_valid",  64'(m_valid), 64'd0);
      chk("rst_m_user",   64'(m_user),  64'd0);
      chk("rst_m_last",   64'(m_last),  64'd0);
      chk("rst_cfg_err",  64'(cfg_err), 64'd0);
      areset = 1'b0;
      chk("s_ready_first_cycle", 64'(s_ready), 64'd0);
      tick();
      chk("s_ready_after_reset", 64'(s_ready), 64'd1);

      // 1: kw2=2 cols_1=7 cin_1=1 rows_1=0
      b_out = n_out; b_k2 = n_k2; b_cl = n_cinlast; b_last = n_last;
      send_frame(2'd2, 10'd7, 10'd1, 10'd0, -1, 1'b0);
      drain();
      chk("t1_beats",    64'(n_out - b_out),     64'd17);
      chk("t1_k2",       64'(n_k2 - b_k2),       64'd2);
      chk("t1_cin_last", 64'(n_cinlast - b_cl),  64'd8);
      chk("t1_last",     64'(n_last - b_last),   64'd1);

      // 2: kw2=0 cols_1=3 cin_1=0 rows_1=1
      b_out = n_out; b_k2 = n_k2; b_cl = n_cinlast; b_last = n_last;
      send_frame(2'd0, 10'd3, 10'd0, 10'd1, -1, 1'b0);
      drain();
      chk("t2_beats",    64'(n_out - b_out),     64'd9);
      chk("t2_k2",       64'(n_k2 - b_k2),       64'd0);
      chk("t2_cin_last", 64'(n_cinlast - b_cl),  64'd8);
      chk("t2_last",     64'(n_last - b_last),   64'd1);

      // 3: random stalls, three back-to-back frames
      rnd_ready = 1'b1;
      rnd_valid = 1'b1;
      b_out = n_out; b_last = n_last;
      send_frame(2'd3, 10'd5, 10'd2, 10'd1, -1, 1'b0);
      send_frame(2'd1, 10'd2, 10'd0, 10'd2, -1, 1'b0);
      send_frame(2'd2, 10'd4, 10'd1, 10'd1, -1, 1'b0);
      drain();
      rnd_ready = 1'b0;
      rnd_valid = 1'b0;
      m_ready   = 1'b1;
      chk("t3_beats",   64'(n_out - b_out),   64'd68);
      chk("t3_last",    64'(n_last - b_last), 64'd3);
      chk("t3_cfg_err", 64'(cfg_err),         64'd0);

      // 4: kernel wider than frame
      b_k2 = n_k2; b_last = n_last;
      send_frame(2'd3, 10'd1, 10'd0, 10'd0, -1, 1'b1);
      drain();
      chk("t4_k2",      64'(n_k2 - b_k2),     64'd0);
      chk("t4_last",    64'(n_last - b_last), 64'd1);
      chk("t4_cfg_err", 64'(cfg_err),         64'd1);

      // 5: early s_last
      do_reset();
      chk("t5_err_cleared", 64'(cfg_err), 64'd0);
      b_last = n_last;
      send_frame(2'd1, 10'd3, 10'd0, 10'd0, 2, 1'b0);
      drain();
      chk("t5_cfg_err", 64'(cfg_err),         64'd1);
      chk("t5_last",    64'(n_last - b_last), 64'd1);

      // 6: reset mid-row with the skid full
      do_reset();
      m_ready = 1'b0;
      begin
         logic [DW-1:0] w;
         logic [UW-1:0] u;
         w = {$urandom, $urandom};
         w[31:0] = {10'd1, 10'd1, 10'd3, 2'd1};
         u = '0;
         u[I_IS_CONFIG] = 1'b1;
         u[I_KW2 +: BITS_KW2] = 2'd1;
         exp_q.push_back({w, u, 1'b0});
         send_beat(w, 1'b0);
         w = {$urandom, $urandom};
         u = '0;
         u[I_KW2 +: BITS_KW2] = 2'd1;
         exp_q.push_back({w, u, 1'b0});
         send_beat(w, 1'b0);
      end
      chk("t6_skid_full_s_ready", 64'(s_ready), 64'd0);
      chk("t6_m_valid_held",      64'(m_valid), 64'd1);
      areset = 1'b1;
      exp_q.delete();
      #1;
      chk("t6_m_valid_in_reset", 64'(m_valid), 64'd0);
      tick();
      chk("t6_m_valid_next", 64'(m_valid), 64'd0);
      areset  = 1'b0;
      m_ready = 1'b1;
      b_out = n_out; b_k2 = n_k2; b_last = n_last;
      send_frame(2'd1, 10'd3, 10'd1, 10'd1, -1, 1'b0);
      drain();
      chk("t6_beats",   64'(n_out - b_out),   64'd17);
      chk("t6_k2",      64'(n_k2 - b_k2),     64'd4);
      chk("t6_last",    64'(n_last - b_last), 64'd1);
      chk("t6_cfg_err", 64'(cfg_err),         64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
